instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/riscvx_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 46 ++++
 rtl/instr_fetch_unit.sv | 82 ++++++++
 tb/tb_instr_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/riscvx_pkg.sv
// Shared fetch-path definitions: queue depth, bubble instruction, queue entry layout.
package riscvx_pkg;

  localparam int          FQ_DEPTH  = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular fetch queue with push/pop/flush and an occupancy count.
module fetch_fifo
  import riscvx_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fq_entry_t     wdata,
  output fq_entry_t     rdata,
  output logic [CW-1:0] count
);

  fq_entry_t         mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rdata = mem[rd_ptr];

  // Pointers and count; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage needs no reset; count decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch issue/flush control in front of a 2-entry fetch queue.
// A request issued in cycle t returns data in t+1 and is pushed at the end of t+1.
module instr_fetch_unit #(
  parameter int          FQ_DEPTH  = riscvx_pkg::FQ_DEPTH,
  parameter logic [31:0] NOP_INSTR = riscvx_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_next,
  input  logic        j_br,
  input  logic        HDU_stall,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        fetch_stall,
  output logic        valid_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] instr_ID,
  output logic        misalign_ID
);
  import riscvx_pkg::*;

  localparam int CW = $clog2(FQ_DEPTH + 1);
  localparam int OW = CW + 1;

  logic          inflight_q, inflight_mis_q;
  logic [31:0]   inflight_pc_q;
  logic [CW-1:0] fq_count;
  logic [OW-1:0] occ;
  logic          deq, push;
  fq_entry_t     head, push_data;

  // Issue only if the queue can absorb the response after this cycle's pop;
  // a redirect always issues because the flush makes room.
  assign valid_ID    = ~reset & (fq_count != '0) & ~j_br;
  assign deq         = valid_ID & ~HDU_stall;
  assign occ         = OW'(fq_count) + OW'(inflight_q) - OW'(deq);
  assign imem_en     = ~reset & (j_br | (occ <= OW'(1)));
  assign fetch_stall = ~imem_en;
  assign imem_addr   = {PC_next[31:2], 2'b00};

  // The response landing during a redirect belongs to the old path.
  assign push      = inflight_q & ~j_br;
  assign push_data = '{pc: inflight_pc_q, instr: imem_rdata, misalign: inflight_mis_q};

  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (deq),
    .flush (j_br),
    .wdata (push_data),
    .rdata (head),
    .count (fq_count)
  );

  // Track the single outstanding request and the PC it was issued for.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= imem_en;
      if (imem_en) begin
        inflight_pc_q  <= PC_next;
        inflight_mis_q <= (PC_next[1:0] != 2'b00);
      end
    end
  end

  // Head presentation; an empty queue shows a bubble.
  always_comb begin
    PC_ID       = '0;
    instr_ID    = NOP_INSTR;
    misalign_ID = 1'b0;
    if (fq_count != '0) begin
      PC_ID       = head.pc;
      instr_ID    = head.instr;
      misalign_ID = head.misalign;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a queue-based reference model.
module tb_instr_fetch_unit;
  import riscvx_pkg::*;

  logic        clk = 1'b0;
  logic        reset, j_br, HDU_stall;
  logic [31:0] PC_next, imem_rdata;
  logic        imem_en, fetch_stall, valid_ID, misalign_ID;
  logic [31:0] imem_addr, PC_ID, instr_ID;

  always #5 clk = ~clk;

  instr_fetch_unit #(.FQ_DEPTH(2), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .PC_next(PC_next), .j_br(j_br), .HDU_stall(HDU_stall),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .fetch_stall(fetch_stall), .valid_ID(valid_ID), .PC_ID(PC_ID),
    .instr_ID(instr_ID), .misalign_ID(misalign_ID)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: answers whatever the DUT requested, one cycle later.
  logic        en_s = 1'b0;
  logic [31:0] addr_s = '0;
  always @(posedge clk) begin
    #1;
    imem_rdata = en_s ? memf(addr_s) : 32'hDEAD_BEEF;
  end

  // Reference model: list of queued entries plus one outstanding request.
  fq_entry_t   mq[$];
  logic        m_inf = 1'b0, m_mis = 1'b0, m_en = 1'b0;
  logic [31:0] m_pc = '0;

  always @(negedge clk) begin
    logic      e_valid, e_deq, e_en;
    int        occ;
    fq_entry_t eh;
    en_s   = imem_en;
    addr_s = imem_addr;
    if (reset) begin
      chk("rst_imem_en", imem_en, 1'b0);
      chk("rst_fetch_stall", fetch_stall, 1'b1);
      chk("rst_valid", valid_ID, 1'b0);
      mq.delete();
      m_inf = 1'b0;
      m_en  = 1'b0;
    end else begin
      e_valid = (mq.size() != 0) && !j_br;
      e_deq   = e_valid && !HDU_stall;
      occ     = mq.size() + int'(m_inf) - int'(e_deq);
      e_en    = j_br || (occ <= 1);
      if (mq.size() != 0) eh = mq[0];
      else eh = '{pc: 32'h0, instr: 32'h0000_0013, misalign: 1'b0};
      chk("imem_en", imem_en, e_en);
      chk("fetch_stall", fetch_stall, !e_en);
      chk("imem_addr", imem_addr, {PC_next[31:2], 2'b00});
      chk("valid_ID", valid_ID, e_valid);
      chk("PC_ID", PC_ID, eh.pc);
      chk("instr_ID", instr_ID, eh.instr);
      chk("misalign_ID", misalign_ID, eh.misalign);
      // The queue must never be asked to take a third entry.
      checks++;
      assert (!(!j_br && dut.inflight_q && dut.fq_count == 2'd2 && !(valid_ID && !HDU_stall)))
      else begin
        errors++;
        $display("FAIL overflow_push: push into full queue (t=%0t)", $time);
      end
      if (j_br) mq.delete();
      else begin
        if (e_deq) void'(mq.pop_front());
        if (m_inf) mq.push_back('{pc: m_pc, instr: imem_rdata, misalign: m_mis});
      end
      m_inf = e_en;
      m_pc  = PC_next;
      m_mis = (PC_next[1:0] != 2'b00);
      m_en  = e_en;
    end
  end

  // Next cycle; the PC advances only if the previous cycle issued a request.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_en) PC_next = PC_next + 32'd4;
  endtask

  initial begin
    reset = 1'b1; j_br = 1'b0; HDU_stall = 1'b0; PC_next = '0; imem_rdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pin_rst_en", imem_en, 1'b0);
    chk("pin_rst_valid", valid_ID, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; PC_next = 32'h0;                           // c0
    @(negedge clk); chk("pin_c0_valid", valid_ID, 1'b0);
    chk("pin_c0_instr", instr_ID, 32'h0000_0013);
    tick();                                                  // c1
    tick();                                                  // c2
    @(negedge clk);
    chk("pin_c2_valid", valid_ID, 1'b1);
    chk("pin_c2_pc", PC_ID, 32'h0);
    chk("pin_c2_instr", instr_ID, 32'hC0DE_0000);
    tick(); @(negedge clk); chk("pin_c3_pc", PC_ID, 32'h4);  // c3
    tick(); @(negedge clk); chk("pin_c4_pc", PC_ID, 32'h8);  // c4
    chk("pin_c4_instr", instr_ID, 32'hC0DE_0008);

    // Decode stall for four cycles: head held, fetch throttled.
    tick(); HDU_stall = 1'b1;                                // c5
    tick();                                                  // c6
    tick(); @(negedge clk);                                  // c7
    chk("pin_stall3_fs", fetch_stall, 1'b1);
    chk("pin_stall3_pc", PC_ID, 32'hC);
    tick(); @(negedge clk);                                  // c8
    chk("pin_stall4_fs", fetch_stall, 1'b1);
    chk("pin_stall4_pc", PC_ID, 32'hC);
    tick(); HDU_stall = 1'b0;                                // c9
    @(negedge clk); chk("pin_drain0", PC_ID, 32'hC);
    tick(); @(negedge clk); chk("pin_drain1", PC_ID, 32'h10);
    tick(); @(negedge clk); chk("pin_drain2", PC_ID, 32'h14);

    // Redirect with a full queue while decode is stalled.
    tick(); HDU_stall = 1'b1;                                // c12
    tick(); tick();                                          // c13, c14
    tick(); j_br = 1'b1; PC_next = 32'h100;                  // c15
    @(negedge clk);
    chk("pin_br_valid", valid_ID, 1'b0);
    chk("pin_br_en", imem_en, 1'b1);
    chk("pin_br_addr", imem_addr, 32'h100);
    tick(); j_br = 1'b0; HDU_stall = 1'b0;                   // c16
    @(negedge clk); chk("pin_br1_valid", valid_ID, 1'b0);
    tick(); @(negedge clk);                                  // c17
    chk("pin_br2_valid", valid_ID, 1'b1);
    chk("pin_br2_pc", PC_ID, 32'h100);
    chk("pin_br2_instr", instr_ID, 32'hC0DE_0100);

    // Redirect to a misaligned target while a response is in flight.
    tick(); tick();                                          // c18, c19
    tick(); j_br = 1'b1; PC_next = 32'h102;                  // c20
    @(negedge clk); chk("pin_mis_addr", imem_addr, 32'h100);
    tick(); j_br = 1'b0;                                     // c21
    tick(); @(negedge clk);                                  // c22
    chk("pin_mis_pc", PC_ID, 32'h102);
    chk("pin_mis_flag", misalign_ID, 1'b1);
    chk("pin_mis_instr", instr_ID, 32'hC0DE_0100);
    tick(); @(negedge clk);                                  // c23
    chk("pin_mis2_pc", PC_ID, 32'h106);
    chk("pin_mis2_instr", instr_ID, 32'hC0DE_0104);
    tick(); j_br = 1'b1; PC_next = 32'h200;                  // c24
    tick(); j_br = 1'b0;                                     // c25
    tick(); tick();                                          // c26, c27

    // Reset in the middle of a full queue.
    tick(); HDU_stall = 1'b1;                                // c28
    tick();                                                  // c29
    tick(); reset = 1'b1; HDU_stall = 1'b0;                  // c30
    @(negedge clk); chk("pin_midrst_en", imem_en, 1'b0);
    chk("pin_midrst_valid", valid_ID, 1'b0);
    tick();                                                  // c31
    tick(); reset = 1'b0; PC_next = 32'h40;                  // c32
    @(negedge clk);
    chk("pin_rel_valid", valid_ID, 1'b0);
    chk("pin_rel_instr", instr_ID, 32'h0000_0013);
    chk("pin_rel_en", imem_en, 1'b1);
    tick(); @(negedge clk); chk("pin_rel1_valid", valid_ID, 1'b0);
    tick(); @(negedge clk);                                  // c34
    chk("pin_rel2_pc", PC_ID, 32'h40);
    chk("pin_rel2_instr", instr_ID, 32'hC0DE_0040);
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
